// File: rtl/axi_rd_req_scheduler_pkg.sv
// Shared definitions for the AXI read-request scheduler: FSM state encoding,
// AXI length-field width and the ceil-log2 helper used to size counters.
package axi_rd_req_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } sched_state_e;

    localparam int unsigned AXI_LEN_W = 8;

    // Returns ceil(log2(value)); c_log_2(1) is 0.
    function automatic int unsigned c_log_2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rd_port_burst_gen.sv
// Per-port burst generator: splits the remaining beat count into AXI bursts,
// tracks outstanding bursts and flags completion underflow.
module rd_port_burst_gen
    import axi_rd_req_scheduler_pkg::*;
#(
    parameter int unsigned TX_SIZE_WIDTH   = 10,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned MAX_BURST_LEN   = 16,
    parameter int unsigned BEAT_BYTES      = 8,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     load,
    input  logic                     active,
    input  logic [TX_SIZE_WIDTH-1:0] size,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic                     ar_ready,
    input  logic                     rd_burst_done,
    output logic                     ar_valid,
    output logic [ADDR_WIDTH-1:0]    ar_addr,
    output logic [AXI_LEN_W-1:0]     ar_len,
    output logic                     port_finished,
    output logic                     underflow_err
);

    localparam int unsigned OUT_W      = c_log_2(MAX_OUTSTANDING + 1);
    localparam int unsigned LEN_W      = c_log_2(MAX_BURST_LEN) + 1;
    localparam int unsigned BEAT_SHIFT = c_log_2(BEAT_BYTES);

    logic [TX_SIZE_WIDTH-1:0] rem_q, rem_d;
    logic [ADDR_WIDTH-1:0]    next_addr_q, next_addr_d;
    logic [OUT_W-1:0]         out_q, out_d;
    logic                     err_q, err_d;
    logic                     ar_valid_q, ar_valid_d;
    logic [ADDR_WIDTH-1:0]    ar_addr_q, ar_addr_d;
    logic [AXI_LEN_W-1:0]     ar_len_q, ar_len_d;
    logic                     hs;
    logic                     dn;
    logic [LEN_W-1:0]         cur_len;

    function automatic logic [LEN_W-1:0] burst_len(input logic [TX_SIZE_WIDTH-1:0] rem);
        if (32'(rem) >= MAX_BURST_LEN) begin
            return LEN_W'(MAX_BURST_LEN);
        end
        return LEN_W'(rem);
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rem_q       <= '0;
            next_addr_q <= '0;
            out_q       <= '0;
            err_q       <= 1'b0;
            ar_valid_q  <= 1'b0;
            ar_addr_q   <= '0;
            ar_len_q    <= '0;
        end else begin
            rem_q       <= rem_d;
            next_addr_q <= next_addr_d;
            out_q       <= out_d;
            err_q       <= err_d;
            ar_valid_q  <= ar_valid_d;
            ar_addr_q   <= ar_addr_d;
            ar_len_q    <= ar_len_d;
        end
    end

    always_comb begin
        hs          = ar_valid_q & ar_ready;
        dn          = rd_burst_done & active;
        cur_len     = burst_len(rem_q);
        rem_d       = rem_q;
        next_addr_d = next_addr_q;
        out_d       = out_q;
        err_d       = err_q;
        ar_valid_d  = ar_valid_q;
        ar_addr_d   = ar_addr_q;
        ar_len_d    = ar_len_q;

        if (load) begin
            rem_d       = size;
            next_addr_d = base_addr;
            out_d       = '0;
        end else begin
            if (hs) begin
                rem_d       = rem_q - TX_SIZE_WIDTH'(cur_len);
                next_addr_d = next_addr_q + (ADDR_WIDTH'(cur_len) << BEAT_SHIFT);
            end
            if (hs && !dn) begin
                out_d = out_q + OUT_W'(1);
            end else if (!hs && dn) begin
                if (out_q == '0) begin
                    err_d = 1'b1;
                end else begin
                    out_d = out_q - OUT_W'(1);
                end
            end
        end

        // The AR slice is refilled from the post-update counters so the next
        // burst is presented in the cycle right after a handshake or a release.
        if (load || !(ar_valid_q && !ar_ready)) begin
            ar_valid_d = (rem_d != '0) && (32'(out_d) < MAX_OUTSTANDING);
            if (ar_valid_d) begin
                ar_addr_d = next_addr_d;
                ar_len_d  = AXI_LEN_W'(burst_len(rem_d) - LEN_W'(1));
            end
        end
    end

    always_comb begin
        ar_valid      = ar_valid_q;
        ar_addr       = ar_addr_q;
        ar_len        = ar_len_q;
        port_finished = (rem_q == '0) && (out_d == '0);
        underflow_err = err_q;
    end

endmodule

// File: rtl/axi_rd_req_scheduler.sv
// Read-request scheduler top: global IDLE/ACTIVE/DONE FSM over NUM_AXI
// independent per-port burst generators.
module axi_rd_req_scheduler
    import axi_rd_req_scheduler_pkg::*;
#(
    parameter int unsigned NUM_AXI         = 4,
    parameter int unsigned TX_SIZE_WIDTH   = 10,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned MAX_BURST_LEN   = 16,
    parameter int unsigned BEAT_BYTES      = 8,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            rx_req,
    input  logic [TX_SIZE_WIDTH-1:0]        rx_req_size,
    input  logic [NUM_AXI*ADDR_WIDTH-1:0]   rx_addr,
    output logic                            rx_busy,
    output logic                            rx_done,
    output logic                            rx_req_dropped,
    output logic [NUM_AXI-1:0]              ar_valid,
    input  logic [NUM_AXI-1:0]              ar_ready,
    output logic [NUM_AXI*ADDR_WIDTH-1:0]   ar_addr,
    output logic [NUM_AXI*AXI_LEN_W-1:0]    ar_len,
    input  logic [NUM_AXI-1:0]              rd_burst_done,
    output logic                            protocol_err
);

    sched_state_e        state_q, state_d;
    logic                dropped_q, dropped_d;
    logic                start;
    logic                active;
    logic                all_finished;
    logic [NUM_AXI-1:0]  port_finished;
    logic [NUM_AXI-1:0]  port_err;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dropped_q <= dropped_d;
        end
    end

    always_comb begin
        start        = (state_q == ST_IDLE) && rx_req;
        active       = (state_q == ST_ACTIVE);
        all_finished = &port_finished;
        dropped_d    = rx_req && (state_q != ST_IDLE);
        state_d      = state_q;
        unique case (state_q)
            ST_IDLE:   if (rx_req) state_d = ST_ACTIVE;
            ST_ACTIVE: if (all_finished) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_busy        = (state_q != ST_IDLE);
        rx_done        = (state_q == ST_DONE);
        rx_req_dropped = dropped_q;
        protocol_err   = |port_err;
    end

    for (genvar k = 0; k < NUM_AXI; k++) begin : g_port
        rd_port_burst_gen #(
            .TX_SIZE_WIDTH  (TX_SIZE_WIDTH),
            .ADDR_WIDTH     (ADDR_WIDTH),
            .MAX_BURST_LEN  (MAX_BURST_LEN),
            .BEAT_BYTES     (BEAT_BYTES),
            .MAX_OUTSTANDING(MAX_OUTSTANDING)
        ) u_port (
            .clk          (clk),
            .resetn       (resetn),
            .load         (start),
            .active       (active),
            .size         (rx_req_size),
            .base_addr    (rx_addr[k*ADDR_WIDTH +: ADDR_WIDTH]),
            .ar_ready     (ar_ready[k]),
            .rd_burst_done(rd_burst_done[k]),
            .ar_valid     (ar_valid[k]),
            .ar_addr      (ar_addr[k*ADDR_WIDTH +: ADDR_WIDTH]),
            .ar_len       (ar_len[k*AXI_LEN_W +: AXI_LEN_W]),
            .port_finished(port_finished[k]),
            .underflow_err(port_err[k])
        );
    end

endmodule
